axis_frame_writer: RTL
======================

// Module: axis_frame_writer
// PURPOSE
// - Successor to the stream tagging writer. Accepts raw samples on AXI4-Stream and groups them into frames of cfg_data samples.
// - Each output beat is {misc, sample index, sample}. The last beat of every frame carries tlast.
// - Continuous or one-shot (cfg_frames frames) mode; misc latched per frame; registered output stage.
// - Sits between ADC/DSP chains and the DMA/RAM writers.
// PARAMETERS
// - S_AXIS_TDATA_WIDTH  32  sample width.
// - M_AXIS_TDATA_WIDTH  64  output width; must equal MISC_WIDTH+CNTR_WIDTH+S_AXIS_TDATA_WIDTH.
// - CNTR_WIDTH          16  samples-per-frame / index width.
// - MISC_WIDTH          16  misc field width.
// - FRAME_WIDTH         16  frame counter width.
// PORTS
// - aclk           in   1                    clock.
// - aresetn        in   1                    reset; asynchronous assert, active-low.
// - cfg_data       in   CNTR_WIDTH           samples per frame N; 0 = disabled.
// - cfg_frames     in   FRAME_WIDTH          frames per run in one-shot mode (0 treated as 1).
// - cfg_mode       in   1                    0 continuous, 1 one-shot.
// - misc_data      in   MISC_WIDTH           side data, sampled at the first beat of each frame.
// - sts_frames     out  FRAME_WIDTH          completed frames since run start.
// - sts_busy       out  1                    1 in RUN.
// - s_axis_tready  out  1
// - s_axis_tdata   in   S_AXIS_TDATA_WIDTH
// - s_axis_tvalid  in   1
// - m_axis_tready  in   1
// - m_axis_tdata   out  M_AXIS_TDATA_WIDTH   {misc_lat, index, sample}.
// - m_axis_tvalid  out  1
// - m_axis_tlast   out  1
// BEHAVIOUR
// - Reset: all regs 0; state IDLE; m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, sts_frames=0, sts_busy=0, s_axis_tready=0.
// - FSM IDLE -> RUN: registered cfg_data != 0. On entry, latch N=cfg_data, F=max(cfg_frames,1) and mode; clear index and sts_frames.
// - RUN: s_axis_tready = ~m_axis_tvalid | m_axis_tready (one-deep output register, no bubble at full rate).
// - Accept (s_valid & s_ready): load output register on the next edge, so latency is 1 cycle.
//   - tdata = {misc, idx, s_tdata}; tvalid=1; tlast=(idx==N-1).
//   - idx increments. On idx==N-1, idx returns to 0 and sts_frames increments.
// - misc: for idx==0 the live misc_data is used and latched. Beats idx>0 reuse the latched value, so misc is constant within a frame.
// - Output hold: while m_axis_tvalid & ~m_axis_tready, tdata, tlast and tvalid are held stable. When the register drains with no new accept, tvalid drops to 0.
// - Frame boundary (accept of idx==N-1):
//   - cfg_data==0 -> IDLE.
//   - one-shot and sts_frames+1==F -> DONE.
//   - otherwise stay in RUN and re-latch N, F and mode from cfg at the boundary.
// - cfg changes mid-frame are ignored until the boundary. Frames are never truncated by cfg.
// - DONE: s_axis_tready=0; the output register still drains. Go to IDLE when cfg_data==0 (re-arm).
// - IDLE/DONE: s_axis_tready=0. Output register drains normally.
// - Continuous mode: sts_frames wraps 2^FRAME_WIDTH-1 -> 0 with no stall.
// - N=1: every beat has idx=0 and tlast=1, and misc is sampled on every beat.
// - N=2^CNTR_WIDTH-1: idx reaches N-1 and then wraps to 0. Index arithmetic is modulo 2^CNTR_WIDTH.
// - Same-cycle accept and drain: allowed; the register reloads and tvalid stays 1.
// - Reset mid-frame: output cleared immediately (async). The partial frame is dropped, with no tlast emitted.
// STRUCTURE
// - Shared package axis_frame_pkg:
//   - state encodings IDLE=2'd0, RUN=2'd1, DONE=2'd2;
//   - mode constants MODE_CONT=1'b0, MODE_ONESHOT=1'b1.
// - Sub-module axis_frame_writer_oreg: one-deep output register with ready-through (tdata/tlast/tvalid).
// - Top holds the FSM, index/frame counters and misc latch.
// TESTING
// - N=4, continuous, tready=1, 12 samples 0..11, misc=0xA5 -> 12 beats, idx 0,1,2,3 repeating, tlast on beats 3,7,11, sts_frames=3, misc=0xA5.
// - N=3, one-shot F=2, 10 samples offered -> exactly 6 beats, then DONE with s_tready=0, sts_frames=2. Set cfg_data=0 then 3 -> new run, sts_frames back to 0.
// - Toggle m_axis_tready 1,0,0,1 repeatedly (stall with valid high), N=5 -> tdata held stable during stalls, no loss or duplication, tlast on idx 4.
// - misc_data changes every cycle, N=4 -> all 4 beats of each frame carry the misc value present at the idx-0 accept.
// - Set cfg_data 4->2 at idx 1 -> current frame completes 4 beats, and the next frames are 2 beats each.
// - Assert aresetn=0 mid-frame (idx 2) -> m_axis_tvalid=0 with no clock edge. After release, IDLE; restart from idx 0, sts_frames=0.
// - FRAME_WIDTH=4, N=1, continuous, 17 beats -> sts_frames wraps 15->0 at beat 16 and reads 1 after beat 17.

Source files
------------

// File: rtl/axis_frame_writer_pkg.sv
// Shared FSM state encoding and run-mode constants for the AXI-Stream frame writer.
package axis_frame_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic MODE_CONT    = 1'b0;
  localparam logic MODE_ONESHOT = 1'b1;

endpackage

// File: rtl/axis_frame_writer_if.sv
// AXI-Stream bundle shared by the sample input and the framed output of the writer.
interface axis_frame_writer_if #(
  parameter int DATA_WIDTH = 32
) ();

  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  // The sample input side never looks at tlast, so the slave view leaves it out.
  modport slave  (input tdata, input tvalid, output tready);

endinterface

// File: rtl/axis_frame_writer_oreg.sv
// One-deep output register: a load wins over a drain, so a same-cycle accept and drain keeps tvalid high.
module axis_frame_writer_oreg #(
  parameter int DATA_WIDTH = 64
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  load_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  last_i,
  input  logic                  ready_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  last_o,
  output logic                  valid_o
);

  logic [DATA_WIDTH-1:0] data_q;
  logic                  last_q;
  logic                  valid_q;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      data_q  <= '0;
      last_q  <= 1'b0;
      valid_q <= 1'b0;
    end else if (load_i) begin
      data_q  <= data_i;
      last_q  <= last_i;
      valid_q <= 1'b1;
    end else if (ready_i) begin
      valid_q <= 1'b0;
    end
  end

  assign data_o  = data_q;
  assign last_o  = last_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/axis_frame_writer.sv
// Groups incoming samples into frames of N beats tagged {misc, index, sample}, with continuous or one-shot runs.
module axis_frame_writer
  import axis_frame_pkg::*;
#(
  parameter int S_AXIS_TDATA_WIDTH = 32,
  parameter int M_AXIS_TDATA_WIDTH = 64,
  parameter int CNTR_WIDTH         = 16,
  parameter int MISC_WIDTH         = 16,
  parameter int FRAME_WIDTH        = 16
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  input  logic [CNTR_WIDTH-1:0]  cfg_data,
  input  logic [FRAME_WIDTH-1:0] cfg_frames,
  input  logic                   cfg_mode,
  input  logic [MISC_WIDTH-1:0]  misc_data,
  output logic [FRAME_WIDTH-1:0] sts_frames,
  output logic                   sts_busy,
  axis_frame_writer_if.slave     s_axis,
  axis_frame_writer_if.master    m_axis
);

  state_e state_q, state_d;

  logic [CNTR_WIDTH-1:0]         frameLen_q, frameLen_d;
  logic [CNTR_WIDTH-1:0]         idx_q, idx_d;
  logic [FRAME_WIDTH-1:0]        frameTarget_q, frameTarget_d;
  logic [FRAME_WIDTH-1:0]        frameCnt_q, frameCnt_d;
  logic                          mode_q, mode_d;
  logic [MISC_WIDTH-1:0]         misc_q, misc_d;

  logic [FRAME_WIDTH-1:0]        cfgFramesSat;
  logic [MISC_WIDTH-1:0]         miscSel;
  logic                          sTready;
  logic                          accept;
  logic                          lastBeat;
  logic [M_AXIS_TDATA_WIDTH-1:0] oregData;
  logic                          oregLast;
  logic                          oregValid;

  assign cfgFramesSat = (cfg_frames == '0) ? FRAME_WIDTH'(1) : cfg_frames;
  assign accept       = s_axis.tvalid & sTready;
  assign lastBeat     = (idx_q == frameLen_q - CNTR_WIDTH'(1));
  // The first beat of a frame takes misc live so it matches what gets latched for the rest.
  assign miscSel      = (idx_q == '0) ? misc_data : misc_q;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (cfg_data != '0) state_d = RUN;
      end
      RUN: begin
        if (accept && lastBeat) begin
          if (cfg_data == '0) begin
            state_d = IDLE;
          end else if (mode_q == MODE_ONESHOT &&
                       frameCnt_q + FRAME_WIDTH'(1) == frameTarget_q) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        if (cfg_data == '0) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    sTready  = 1'b0;
    sts_busy = 1'b0;
    if (state_q == RUN) begin
      sts_busy = 1'b1;
      sTready  = ~oregValid | m_axis.tready;
    end
  end

  // Frame geometry is only re-read from cfg at run entry and at frame boundaries.
  always_comb begin
    frameLen_d    = frameLen_q;
    frameTarget_d = frameTarget_q;
    mode_d        = mode_q;
    idx_d         = idx_q;
    frameCnt_d    = frameCnt_q;
    misc_d        = misc_q;
    if (state_q == IDLE && cfg_data != '0) begin
      frameLen_d    = cfg_data;
      frameTarget_d = cfgFramesSat;
      mode_d        = cfg_mode;
      idx_d         = '0;
      frameCnt_d    = '0;
    end else if (accept) begin
      if (idx_q == '0) misc_d = misc_data;
      if (lastBeat) begin
        idx_d      = '0;
        frameCnt_d = frameCnt_q + FRAME_WIDTH'(1);
        if (state_d == RUN) begin
          frameLen_d    = cfg_data;
          frameTarget_d = cfgFramesSat;
          mode_d        = cfg_mode;
        end
      end else begin
        idx_d = idx_q + CNTR_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      frameLen_q    <= '0;
      frameTarget_q <= '0;
      mode_q        <= MODE_CONT;
      idx_q         <= '0;
      frameCnt_q    <= '0;
      misc_q        <= '0;
    end else begin
      frameLen_q    <= frameLen_d;
      frameTarget_q <= frameTarget_d;
      mode_q        <= mode_d;
      idx_q         <= idx_d;
      frameCnt_q    <= frameCnt_d;
      misc_q        <= misc_d;
    end
  end

  axis_frame_writer_oreg #(
    .DATA_WIDTH(M_AXIS_TDATA_WIDTH)
  ) u_oreg (
    .aclk   (aclk),
    .aresetn(aresetn),
    .load_i (accept),
    .data_i ({miscSel, idx_q, s_axis.tdata}),
    .last_i (lastBeat),
    .ready_i(m_axis.tready),
    .data_o (oregData),
    .last_o (oregLast),
    .valid_o(oregValid)
  );

  assign s_axis.tready = sTready;
  assign m_axis.tdata  = oregData;
  assign m_axis.tlast  = oregLast;
  assign m_axis.tvalid = oregValid;
  assign sts_frames    = frameCnt_q;

endmodule
